// File: rtl/mem_io_bridge_if.sv
// CPU byte-bus bundle between the cpu top and mem_io_bridge.
// The master drives address/data/write strobe; the slave answers with read data and back-pressure.
interface mem_io_bridge_if;
    logic [31:0] cpu_mem_a;
    logic [7:0]  cpu_mem_dout;
    logic        cpu_mem_wr;
    logic [7:0]  cpu_mem_din;
    logic        io_buffer_full;

    modport master (
        output cpu_mem_a,
        output cpu_mem_dout,
        output cpu_mem_wr,
        input  cpu_mem_din,
        input  io_buffer_full
    );

    modport slave (
        input  cpu_mem_a,
        input  cpu_mem_dout,
        input  cpu_mem_wr,
        output cpu_mem_din,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Decodes the cpu byte bus into block RAM and memory-mapped I/O (UART RX/TX, cycle counter, stop).
// Read data appears one cycle after the read address; UART output is buffered in a small TX FIFO.
module mem_io_bridge #(
    parameter int RAM_AW      = 17,
    parameter int FIFO_AW     = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    mem_io_bridge_if.slave    cpu,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_pop,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              program_stop,
    output logic              tx_overflow
);
    localparam int DEPTH        = 1 << FIFO_AW;
    localparam int DEPTH_I      = DEPTH;
    localparam int FULL_LEVEL_I = DEPTH - FULL_MARGIN;
    localparam logic [FIFO_AW:0] DEPTH_V    = DEPTH_I[FIFO_AW:0];
    localparam logic [FIFO_AW:0] FULL_LEVEL = FULL_LEVEL_I[FIFO_AW:0];

    typedef enum logic [2:0] {
        SEL_RAM  = 3'd0,
        SEL_RX   = 3'd1,
        SEL_CNT0 = 3'd2,
        SEL_CNT1 = 3'd3,
        SEL_CNT2 = 3'd4,
        SEL_CNT3 = 3'd5,
        SEL_ZERO = 3'd6
    } rd_sel_e;

    logic [17:0] addr;
    logic        is_io, rd_acc, wr_acc, is_tx_addr, is_stop_addr;

    assign addr         = cpu.cpu_mem_a[17:0];
    assign is_io        = (addr[17:16] == 2'b11);
    assign is_tx_addr   = (addr == 18'h30000);
    assign is_stop_addr = (addr == 18'h30004);
    assign rd_acc       = rdy_in && !rst_in && !cpu.cpu_mem_wr;
    assign wr_acc       = rdy_in && !rst_in && cpu.cpu_mem_wr;

    assign ram_a   = cpu.cpu_mem_a[RAM_AW-1:0];
    assign ram_din = cpu.cpu_mem_dout;
    assign ram_we  = wr_acc && !is_io;
    assign rx_pop  = rd_acc && is_tx_addr && rx_valid;

    rd_sel_e     rd_sel_q, rd_sel_d;
    logic        rd_pend_q;
    logic [7:0]  din_hold_q, rx_byte_q, rd_byte, din_w;
    logic [31:0] cnt_q, snap_q;
    logic [7:0]  snap_byte [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_snap
        assign snap_byte[gi] = snap_q[8*gi +: 8];
    end

    always_comb begin
        rd_sel_d = rd_sel_q;
        if (rd_acc) begin
            if (!is_io) begin
                rd_sel_d = SEL_RAM;
            end else begin
                case (addr)
                    18'h30000: rd_sel_d = SEL_RX;
                    18'h30004: rd_sel_d = SEL_CNT0;
                    18'h30005: rd_sel_d = SEL_CNT1;
                    18'h30006: rd_sel_d = SEL_CNT2;
                    18'h30007: rd_sel_d = SEL_CNT3;
                    default:   rd_sel_d = SEL_ZERO;
                endcase
            end
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (rd_sel_q)
            SEL_RAM:  rd_byte = ram_dout;
            SEL_RX:   rd_byte = rx_byte_q;
            SEL_CNT0: rd_byte = snap_byte[0];
            SEL_CNT1: rd_byte = snap_byte[1];
            SEL_CNT2: rd_byte = snap_byte[2];
            SEL_CNT3: rd_byte = snap_byte[3];
            default:  rd_byte = 8'h00;
        endcase
    end

    // Only the cycle right after an accepted read shows fresh data; otherwise the last value is held.
    assign din_w           = rd_pend_q ? rd_byte : din_hold_q;
    assign cpu.cpu_mem_din = din_w;

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         tx_last_q, push_byte;
    logic               buf_full_q, stop_q, ovf_q;
    logic               push_req, push_ok, pop, fifo_full;

    assign fifo_full = (count_q == DEPTH_V);
    assign tx_valid  = (count_q != '0);
    assign pop       = tx_valid && tx_ready;
    // The stop byte is queued only by the first stop write.
    assign push_req  = wr_acc && ((is_tx_addr && cpu.cpu_mem_dout != 8'h00) ||
                                  (is_stop_addr && !stop_q));
    assign push_byte = is_stop_addr ? 8'h00 : cpu.cpu_mem_dout;
    assign push_ok   = push_req && (!fifo_full || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign tx_data            = tx_valid ? fifo_mem[rptr_q] : tx_last_q;
    assign cpu.io_buffer_full = buf_full_q;
    assign program_stop       = stop_q;
    assign tx_overflow        = ovf_q;

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wptr_q] <= push_byte;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_sel_q   <= SEL_RAM;
            rd_pend_q  <= 1'b0;
            din_hold_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            snap_q     <= 32'd0;
            cnt_q      <= 32'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            buf_full_q <= 1'b0;
            tx_last_q  <= 8'h00;
            stop_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rd_sel_q   <= rd_sel_d;
            rd_pend_q  <= rd_acc;
            din_hold_q <= din_w;
            if (rd_acc && is_tx_addr) begin
                rx_byte_q <= rx_valid ? rx_data : 8'h00;
            end
            if (rd_acc && is_stop_addr) begin
                snap_q <= cnt_q;
            end
            if (rdy_in) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q    <= rptr_q + 1'b1;
                tx_last_q <= fifo_mem[rptr_q];
            end
            count_q    <= count_d;
            buf_full_q <= (count_d >= FULL_LEVEL);
            if (wr_acc && is_stop_addr) begin
                stop_q <= 1'b1;
            end
            if (push_req && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomized and directed bench for mem_io_bridge with a queue-based scoreboard.
// A reference model predicts read data and TX bytes; a monitor compares what the bridge presents.
module tb_mem_io_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy;
    logic [16:0] ram_a;
    logic [7:0]  ram_din, ram_dout;
    logic        ram_we;
    logic        rx_valid, rx_pop, tx_valid, tx_ready, program_stop, tx_overflow;
    logic [7:0]  rx_data, tx_data;

    mem_io_bridge_if bus();

    mem_io_bridge dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rdy_in       (rdy),
        .cpu          (bus),
        .ram_a        (ram_a),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_dout     (ram_dout),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_pop       (rx_pop),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .program_stop (program_stop),
        .tx_overflow  (tx_overflow)
    );

    // Block RAM environment: synchronous read, read-before-write
    bit [7:0] ram_env [0:131071];
    always @(posedge clk) begin
        if (ram_we) ram_env[ram_a] <= ram_din;
        ram_dout <= ram_env[ram_a];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         occ = 0;
    bit         stop_m = 0, ovf_m = 0;
    logic [31:0] cnt_m = 0, snap_m = 0;
    logic [7:0] ref_mem [int];
    logic [7:0] rd_exp [$];
    logic [7:0] tx_exp [$];

    logic rd_issue = 1'b0;
    logic rd_pipe  = 1'b0;
    logic rst_pipe = 1'b1;
    logic [7:0] din_hold_m = 8'h00;

    always @(posedge clk) begin
        rd_pipe  <= rd_issue;
        rst_pipe <= rst;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: read data the cycle after each accepted read, TX bytes on each handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rst_pipe) begin
                din_hold_m = 8'h00;
            end else if (rd_pipe) begin
                if (rd_exp.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL rd_unexpected: actual %0h expected none", bus.cpu_mem_din);
                end else begin
                    din_hold_m = rd_exp.pop_front();
                    $display("rd  din=%02h exp=%02h", bus.cpu_mem_din, din_hold_m);
                end
            end
            chk("cpu_mem_din", 32'(bus.cpu_mem_din), 32'(din_hold_m));
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                if (tx_exp.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL tx_unexpected: actual %0h expected none", tx_data);
                end else begin
                    logic [7:0] e;
                    e = tx_exp.pop_front();
                    $display("tx  byte=%02h exp=%02h", tx_data, e);
                    chk("tx_data", 32'(tx_data), 32'(e));
                end
            end
        end
    end

    // One bus cycle: drive inputs, predict, check the cycle's outputs, advance.
    task automatic cyc(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [7:0] d, input bit rxv, input logic [7:0] rxd, input bit txr);
        logic [17:0] a18;
        bit io, push, pop, e_full, e_stop, e_ovf, e_txv, e_we, e_rxpop;
        logic [7:0] pb, val;
        int idx;
        a18 = a[17:0];
        io  = (a18 >= 18'h30000);
        rst = r; rdy = rd; bus.cpu_mem_wr = wr; bus.cpu_mem_a = a; bus.cpu_mem_dout = d;
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        e_full  = (16 - occ) <= 2;
        e_stop  = stop_m;
        e_ovf   = ovf_m;
        e_txv   = occ > 0;
        e_we    = !r && rd && wr && !io;
        e_rxpop = !r && rd && !wr && a18 == 18'h30000 && rxv;
        rd_issue = 1'b0;
        push = 0; pb = 8'h00;
        if (!r) begin
            if (rd && !wr) begin
                idx = int'(a[16:0]);
                if (!io) val = ref_mem.exists(idx) ? ref_mem[idx] : 8'h00;
                else if (a18 == 18'h30000) val = rxv ? rxd : 8'h00;
                else if (a18 == 18'h30004) begin snap_m = cnt_m; val = cnt_m[7:0]; end
                else if (a18 == 18'h30005) val = snap_m[15:8];
                else if (a18 == 18'h30006) val = snap_m[23:16];
                else if (a18 == 18'h30007) val = snap_m[31:24];
                else val = 8'h00;
                rd_exp.push_back(val);
                rd_issue = 1'b1;
            end
            if (rd && wr) begin
                if (!io) ref_mem[int'(a[16:0])] = d;
                if (a18 == 18'h30000 && d != 8'h00) begin push = 1; pb = d; end
                if (a18 == 18'h30004) begin
                    if (!stop_m) begin push = 1; pb = 8'h00; end
                    stop_m = 1;
                end
            end
            pop = (occ > 0) && txr;
            if (push) begin
                if (occ < 16 || pop) begin tx_exp.push_back(pb); occ++; end
                else ovf_m = 1;
            end
            if (pop) occ--;
            if (rd) cnt_m++;
        end
        @(negedge clk);
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("rx_pop", 32'(rx_pop), 32'(e_rxpop));
        chk("io_buffer_full", 32'(bus.io_buffer_full), 32'(e_full));
        chk("program_stop", 32'(program_stop), 32'(e_stop));
        chk("tx_overflow", 32'(tx_overflow), 32'(e_ovf));
        chk("tx_valid", 32'(tx_valid), 32'(e_txv));
        if (r) begin
            #1;
            occ = 0; stop_m = 0; ovf_m = 0; cnt_m = 0; snap_m = 0;
            tx_exp.delete();
            rd_exp.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit txr);
        cyc(0, 0, 0, 32'h0, 8'h00, 0, 8'h00, txr);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1; rdy = 0; rx_valid = 0; rx_data = 0; tx_ready = 0;
        bus.cpu_mem_a = 0; bus.cpu_mem_dout = 0; bus.cpu_mem_wr = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h100, 8'h00, 0, 8'h00, 0);
        chk("reset_din", 32'(bus.cpu_mem_din), 32'h0);
        chk("reset_tx_data", 32'(tx_data), 32'h0);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);

        // RAM write then read
        cyc(0, 1, 1, 32'h00100, 8'h5A, 0, 8'h00, 0);
        cyc(0, 1, 0, 32'h00100, 8'h00, 0, 8'h00, 0);
        idle(0);
        // TX: zero byte ignored
        cyc(0, 1, 1, 32'h30000, 8'h41, 0, 8'h00, 1);
        cyc(0, 1, 1, 32'h30000, 8'h00, 0, 8'h00, 1);
        cyc(0, 1, 1, 32'h30000, 8'h42, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) idle(1);
        // Fill to overflow, then drain in order
        for (int i = 0; i < 17; i++) cyc(0, 1, 1, 32'h30000, 8'(8'h60 + i), 0, 8'h00, 0);
        for (int i = 0; i < 18; i++) idle(1);
        // Snapshot bytes: stale (reset) snapshot, then a fresh capture
        cyc(0, 1, 0, 32'h30005, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'h30004 + i, 8'h00, 0, 8'h00, 0);
        idle(0);
        cyc(0, 1, 0, 32'h30006, 8'h00, 0, 8'h00, 0);
        // RX with and without a byte available; hold across rdy low
        cyc(0, 1, 0, 32'h30000, 8'h00, 1, 8'h33, 0);
        idle(0);
        cyc(0, 1, 0, 32'h30000, 8'h00, 0, 8'h77, 0);
        cyc(0, 1, 0, 32'h00100, 8'h00, 0, 8'h00, 0);
        cyc(0, 0, 0, 32'h30000, 8'h00, 1, 8'h99, 0);
        cyc(0, 0, 1, 32'h00100, 8'hEE, 0, 8'h00, 0);
        cyc(0, 1, 1, 32'h00101, 8'hC3, 0, 8'h00, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int kind;
            bit rd, wr;
            logic [7:0] d;
            rd = ($urandom_range(0, 3) != 0);
            wr = $urandom_range(0, 1) == 1;
            kind = $urandom_range(0, 9);
            a = $urandom();
            if (kind <= 3)      a[17:0] = 18'($urandom_range(0, 15));
            else if (kind == 4) a[17:0] = 18'h1FFF0 + 18'($urandom_range(0, 15));
            else if (kind <= 6) a[17:0] = 18'h30000;
            else if (kind == 7) a[17:0] = 18'h30004 + 18'($urandom_range(0, 3));
            else if (kind == 8) a[17:0] = 18'h30008 + 18'($urandom_range(0, 32'hFFF7));
            else                a[17:0] = 18'h30001 + 18'($urandom_range(0, 2));
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            cyc(0, rd, wr, a, d, $urandom_range(0, 1) == 1, 8'($urandom()),
                $urandom_range(0, 2) != 0);
        end

        // Reset with queued TX bytes and a read in the reset cycle
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h30000, 8'h21, 0, 8'h00, 0);
        cyc(1, 1, 0, 32'h00100, 8'h00, 0, 8'h00, 0);
        idle(1);
        idle(1);

        // Stop write with rdy toggling; a second stop write queues nothing
        cyc(0, 0, 1, 32'h30004, 8'hAA, 0, 8'h00, 0);
        cyc(0, 1, 1, 32'h30004, 8'hAA, 0, 8'h00, 0);
        cyc(0, 0, 0, 32'h0, 8'h00, 0, 8'h00, 0);
        cyc(0, 1, 1, 32'h30004, 8'h55, 0, 8'h00, 0);
        cyc(0, 1, 0, 32'h30004, 8'h00, 0, 8'h00, 0);
        cyc(0, 1, 0, 32'h30005, 8'h00, 0, 8'h00, 0);

        for (int i = 0; i < 40 && occ > 0; i++) idle(1);
        idle(1);
        chk("tx_drained", 32'(tx_exp.size()), 32'd0);
        chk("rd_consumed", 32'(rd_exp.size()), 32'd0);
        chk("stop_sticky", 32'(program_stop), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
